// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, 7-bit address + R/W, ACK check, one data
// byte written or read, then STOP. SCL is push-pull; SDA is open-drain
// through SDA_OE. Every bus slot is four quarters of CLK_DIV clocks each.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | bus idle, waiting for ENB && START
// S_START | START condition slot
// S_ADDR  | 8 slots: address MSB first, R/W last
// S_AACK  | address ACK slot, SDA released and sampled
// S_WR    | 8 slots: write byte MSB first
// S_WACK  | write ACK slot, SDA released and sampled
// S_RD    | 8 slots: SDA released, bits shifted in MSB first
// S_MACK  | master NACK slot (single-byte read), read byte published
// S_STOP  | STOP condition slot
// S_DONE  | one-cycle completion pulse
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENB,
    input  logic       START,
    input  logic [6:0] ADDR,
    input  logic       RW,
    input  logic [7:0] WDATA,
    input  logic       SDA_IN,
    output logic       SCL,
    output logic       SDA_OE,
    output logic [7:0] RDATA,
    output logic       BUSY,
    output logic       DONE,
    output logic       ACK_ERR
);

    localparam int            QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_MACK, S_STOP, S_DONE
    } state_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic [7:0]    wdata_q;
    logic          rw_q;
    logic          sda_meta;
    logic          sda_sync;

    // Pad levels {scl, sda_oe} for a given slot type and quarter; bit_val is
    // the data bit being sent in address/write slots.
    function automatic logic [1:0] pins(input state_t st, input logic [1:0] q,
                                        input logic bit_val);
        case (st)
            S_START:                    pins = {q != 2'd3, q != 2'd0};
            S_ADDR, S_WR:               pins = {q[1], ~bit_val};
            S_AACK, S_WACK, S_RD, S_MACK: pins = {q[1], 1'b0};
            S_STOP:                     pins = {q != 2'd0, ~q[1]};
            default:                    pins = 2'b10;
        endcase
    endfunction

    // Two-flop synchroniser for the SDA pad level.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= SDA_IN;
            sda_sync <= sda_meta;
        end
    end

    // Transaction FSM with quarter/slot timing and registered pad outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= S_IDLE;
            qcnt          <= '0;
            quarter       <= 2'd0;
            bit_cnt       <= 3'd0;
            tx_sr         <= 8'd0;
            rx_sr         <= 8'd0;
            wdata_q       <= 8'd0;
            rw_q          <= 1'b0;
            {SCL, SDA_OE} <= 2'b10;
            RDATA         <= 8'd0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ACK_ERR       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ENB && START) begin
                        state         <= S_START;
                        tx_sr         <= {ADDR, RW};
                        wdata_q       <= WDATA;
                        rw_q          <= RW;
                        qcnt          <= '0;
                        quarter       <= 2'd0;
                        BUSY          <= 1'b1;
                        ACK_ERR       <= 1'b0;
                        {SCL, SDA_OE} <= pins(S_START, 2'd0, 1'b0);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    if (qcnt != Q_LAST) begin
                        qcnt <= qcnt + 1'b1;
                    end else if (quarter != 2'd3) begin
                        qcnt          <= '0;
                        quarter       <= quarter + 2'd1;
                        {SCL, SDA_OE} <= pins(state, quarter + 2'd1, tx_sr[7]);
                    end else begin
                        // Slot boundary: pick the next slot and drive its Q0 levels.
                        qcnt    <= '0;
                        quarter <= 2'd0;
                        case (state)
                            S_START: begin
                                state         <= S_ADDR;
                                bit_cnt       <= 3'd0;
                                {SCL, SDA_OE} <= pins(S_ADDR, 2'd0, tx_sr[7]);
                            end
                            S_ADDR, S_WR: begin
                                if (bit_cnt == 3'd7) begin
                                    state         <= (state == S_ADDR) ? S_AACK : S_WACK;
                                    {SCL, SDA_OE} <= pins(S_AACK, 2'd0, 1'b0);
                                end else begin
                                    bit_cnt       <= bit_cnt + 3'd1;
                                    tx_sr         <= {tx_sr[6:0], 1'b0};
                                    {SCL, SDA_OE} <= pins(state, 2'd0, tx_sr[6]);
                                end
                            end
                            S_AACK: begin
                                bit_cnt <= 3'd0;
                                if (sda_sync) begin
                                    ACK_ERR       <= 1'b1;
                                    state         <= S_STOP;
                                    {SCL, SDA_OE} <= pins(S_STOP, 2'd0, 1'b0);
                                end else if (rw_q) begin
                                    state         <= S_RD;
                                    {SCL, SDA_OE} <= pins(S_RD, 2'd0, 1'b0);
                                end else begin
                                    state         <= S_WR;
                                    tx_sr         <= wdata_q;
                                    {SCL, SDA_OE} <= pins(S_WR, 2'd0, wdata_q[7]);
                                end
                            end
                            S_WACK: begin
                                if (sda_sync) ACK_ERR <= 1'b1;
                                state         <= S_STOP;
                                {SCL, SDA_OE} <= pins(S_STOP, 2'd0, 1'b0);
                            end
                            S_RD: begin
                                rx_sr         <= {rx_sr[6:0], sda_sync};
                                {SCL, SDA_OE} <= pins(S_RD, 2'd0, 1'b0);
                                if (bit_cnt == 3'd7) state <= S_MACK;
                                else bit_cnt <= bit_cnt + 3'd1;
                            end
                            S_MACK: begin
                                RDATA         <= rx_sr;
                                state         <= S_STOP;
                                {SCL, SDA_OE} <= pins(S_STOP, 2'd0, 1'b0);
                            end
                            S_STOP: begin
                                state         <= S_DONE;
                                DONE          <= 1'b1;
                                BUSY          <= 1'b0;
                                {SCL, SDA_OE} <= 2'b10;
                            end
                            default: begin
                                state         <= S_IDLE;
                                {SCL, SDA_OE} <= 2'b10;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: an event-level I2C target model watches the bus
// (START/STOP, bits on SCL rise, drives on SCL fall) and each transaction is
// checked against values computed from the address/data/ack choices.
module tb_i2c_master;

    localparam int CLK_DIV  = 4;
    localparam int SLOT     = 4 * CLK_DIV;
    localparam int FULL_LAT = 20 * SLOT;
    localparam int NACK_LAT = 11 * SLOT;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b0;
    logic       ENB   = 1'b0;
    logic       START = 1'b0;
    logic [6:0] ADDR  = 7'd0;
    logic       RW    = 1'b0;
    logic [7:0] WDATA = 8'd0;
    logic       SDA_IN;
    logic       SCL;
    logic       SDA_OE;
    logic [7:0] RDATA;
    logic       BUSY;
    logic       DONE;
    logic       ACK_ERR;

    int total = 0;
    int bad   = 0;

    logic       slv_sda     = 1'b1;
    logic [6:0] slv_addr    = 7'h54;
    logic       slv_present = 1'b1;
    logic       slv_wack    = 1'b1;
    logic [7:0] slv_rbyte   = 8'h00;
    logic       slv_match   = 1'b0;
    logic [7:0] slv_hdr     = 8'h00;
    int         bit_idx     = 0;
    logic       prev_scl    = 1'b1;
    logic       prev_sda    = 1'b1;
    logic       frame_bits[$];
    int         starts      = 0;
    int         stops       = 0;
    int         scl_falls   = 0;
    int         done_cnt    = 0;
    logic [7:0] model_rdata = 8'h00;

    assign SDA_IN = ~SDA_OE & slv_sda;

    always #5 CLK = ~CLK;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .START(START), .ADDR(ADDR), .RW(RW),
        .WDATA(WDATA), .SDA_IN(SDA_IN), .SCL(SCL), .SDA_OE(SDA_OE), .RDATA(RDATA),
        .BUSY(BUSY), .DONE(DONE), .ACK_ERR(ACK_ERR)
    );

    // Target model, sampled mid-cycle so the pad levels are settled.
    always @(negedge CLK) begin : slave_model
        logic sda;
        sda = SDA_IN;
        if (DONE === 1'b1) done_cnt++;
        if (prev_scl && SCL && prev_sda && !sda) begin
            starts++;
            bit_idx   = 0;
            slv_match = 1'b0;
            frame_bits.delete();
            slv_sda   = 1'b1;
        end else if (prev_scl && SCL && !prev_sda && sda) begin
            stops++;
        end else if (!prev_scl && SCL) begin
            frame_bits.push_back(sda);
            if (bit_idx < 8) slv_hdr = {slv_hdr[6:0], sda};
            bit_idx++;
        end else if (prev_scl && !SCL) begin
            scl_falls++;
            slv_sda = 1'b1;
            if (bit_idx == 8) begin
                slv_match = slv_present && (slv_hdr[7:1] == slv_addr);
                slv_sda   = ~slv_match;
            end else if (slv_match && slv_hdr[0] && bit_idx >= 9 && bit_idx <= 16) begin
                slv_sda = slv_rbyte[3'(16 - bit_idx)];
            end else if (slv_match && !slv_hdr[0] && bit_idx == 17) begin
                slv_sda = ~slv_wack;
            end
        end
        prev_scl = SCL;
        prev_sda = sda;
    end

    function automatic logic [31:0] pack_frame();
        logic [31:0] v;
        v = 32'd0;
        foreach (frame_bits[i]) v = {v[30:0], frame_bits[i]};
        return v;
    endfunction

    // Waits for DONE; lat is the number of edges after the accept edge, -1 on timeout.
    task automatic wait_done(input int limit, input int pulse_at, output int lat);
        lat = 0;
        while (lat < limit) begin
            @(posedge CLK);
            lat++;
            #1;
            if (pulse_at >= 0) begin
                START = (lat == pulse_at);
                if (lat == pulse_at) ENB = 1'b0;
            end
            if (DONE === 1'b1) return;
        end
        lat = -1;
    endtask

    task automatic do_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                          input logic present, input logic wack, input logic [7:0] rb,
                          input int pulse_at, input string tag);
        logic        exp_err;
        logic [7:0]  exp_rdata;
        logic [31:0] exp_fv;
        int          exp_lat;
        int          exp_len;
        int          lat;
        int          s0;
        exp_err   = ~present | (~r & ~wack);
        exp_rdata = (present & r) ? rb : model_rdata;
        exp_lat   = present ? FULL_LAT : NACK_LAT;
        if (!present) begin
            exp_fv  = {22'd0, a, r, 1'b1, 1'b0};
            exp_len = 10;
        end else if (r) begin
            exp_fv  = {13'd0, a, r, 1'b0, rb, 1'b1, 1'b0};
            exp_len = 19;
        end else begin
            exp_fv  = {13'd0, a, r, 1'b0, wd, ~wack, 1'b0};
            exp_len = 19;
        end

        @(negedge CLK);
        slv_addr = a; slv_present = present; slv_wack = wack; slv_rbyte = rb;
        ADDR = a; RW = r; WDATA = wd; ENB = 1'b1; START = 1'b1;
        s0 = stops;
        @(posedge CLK);
        #1;
        START = 1'b0;
        ADDR = ~a; RW = ~r; WDATA = ~wd;
        total++;
        if (BUSY !== 1'b1) begin
            bad++; $display("FAIL %s busy_on_accept: got %b want 1", tag, BUSY);
        end
        wait_done(exp_lat + 4 * SLOT, pulse_at, lat);
        total++;
        if (lat !== exp_lat) begin
            bad++; $display("FAIL %s done_latency: got %0d edges want %0d", tag, lat, exp_lat);
        end
        total++;
        if (BUSY !== 1'b0) begin
            bad++; $display("FAIL %s busy_with_done: got %b want 0", tag, BUSY);
        end
        total++;
        if (ACK_ERR !== exp_err) begin
            bad++; $display("FAIL %s ack_err: got %b want %b", tag, ACK_ERR, exp_err);
        end
        total++;
        if (RDATA !== exp_rdata) begin
            bad++; $display("FAIL %s rdata: got %h want %h", tag, RDATA, exp_rdata);
        end
        @(posedge CLK);
        #1;
        total++;
        if (DONE !== 1'b0) begin
            bad++; $display("FAIL %s done_width: got %b want 0", tag, DONE);
        end
        total++;
        if (frame_bits.size() != exp_len || pack_frame() !== exp_fv) begin
            bad++;
            $display("FAIL %s sda_frame: got %0d bits %h want %0d bits %h",
                     tag, frame_bits.size(), pack_frame(), exp_len, exp_fv);
        end
        total++;
        if (stops - s0 !== 1) begin
            bad++; $display("FAIL %s stop_count: got %0d want 1", tag, stops - s0);
        end
        model_rdata = exp_rdata;
        ENB = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0; ENB = 1'b0; START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (SCL !== 1'b1) begin bad++; $display("FAIL reset_scl: got %b want 1", SCL); end
        total++; if (SDA_OE !== 1'b0) begin bad++; $display("FAIL reset_sda_oe: got %b want 0", SDA_OE); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", DONE); end
        total++; if (ACK_ERR !== 1'b0) begin bad++; $display("FAIL reset_ack_err: got %b want 0", ACK_ERR); end
        total++; if (RDATA !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", RDATA); end
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_write();
        do_txn(7'h54, 1'b0, 8'hB8, 1'b1, 1'b1, 8'h00, -1, "write_54");
    endtask

    task automatic test_read();
        do_txn(7'h54, 1'b1, 8'h00, 1'b1, 1'b1, 8'hBE, -1, "read_54");
    endtask

    task automatic test_addr_nack();
        do_txn(7'h54, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00, -1, "addr_nack");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [6:0] a;
            logic       r;
            logic [7:0] wd;
            logic [7:0] rb;
            logic       present;
            logic       wack;
            a       = 7'($urandom);
            r       = 1'($urandom_range(0, 1));
            wd      = 8'($urandom);
            rb      = 8'($urandom);
            present = ($urandom_range(0, 3) != 0);
            wack    = ($urandom_range(0, 3) != 0);
            do_txn(a, r, wd, present, wack, rb, -1, "random");
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        @(negedge CLK);
        slv_addr = 7'h54; slv_present = 1'b1; slv_wack = 1'b1;
        ADDR = 7'h54; RW = 1'b0; WDATA = 8'hB8; ENB = 1'b1; START = 1'b1;
        d0 = done_cnt;
        @(posedge CLK);
        #1;
        START = 1'b0;
        // Slot 13 is the fourth write bit; land in its Q1 (SCL low).
        repeat (13 * SLOT + 5) @(posedge CLK);
        #3;
        total++;
        if (SCL !== 1'b0 || BUSY !== 1'b1) begin
            bad++; $display("FAIL mid_pre_reset: got scl=%b busy=%b want scl=0 busy=1", SCL, BUSY);
        end
        RESET = 1'b0;
        #1;
        total++; if (SCL !== 1'b1) begin bad++; $display("FAIL mid_reset_scl: got %b want 1", SCL); end
        total++; if (SDA_OE !== 1'b0) begin bad++; $display("FAIL mid_reset_sda_oe: got %b want 0", SDA_OE); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", BUSY); end
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        model_rdata = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (RDATA !== 8'h00) begin bad++; $display("FAIL mid_reset_rdata: got %h want 00", RDATA); end
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL mid_reset_no_done: got %0d want %0d", done_cnt, d0); end
        do_txn(7'h54, 1'b0, 8'hB8, 1'b1, 1'b1, 8'h00, -1, "after_reset");
    endtask

    task automatic test_enable_and_busy();
        int f0;
        int d0;
        int busy_seen;
        busy_seen = 0;
        f0 = scl_falls;
        @(negedge CLK);
        ENB = 1'b0; START = 1'b1; ADDR = 7'h2A; RW = 1'b0; WDATA = 8'h5C;
        repeat (3 * SLOT) begin
            @(posedge CLK);
            #1;
            if (BUSY !== 1'b0) busy_seen++;
        end
        START = 1'b0;
        total++;
        if (busy_seen !== 0 || scl_falls !== f0) begin
            bad++; $display("FAIL enb_low_ignored: got busy_cycles=%0d scl_falls=%0d want 0 0",
                            busy_seen, scl_falls - f0);
        end
        d0 = done_cnt;
        do_txn(7'h2A, 1'b0, 8'h5C, 1'b1, 1'b1, 8'h00, 100, "busy_pulse");
        f0 = scl_falls;
        busy_seen = 0;
        repeat (3 * SLOT) begin
            @(posedge CLK);
            #1;
            if (BUSY !== 1'b0) busy_seen++;
        end
        total++;
        if (done_cnt - d0 !== 1 || busy_seen !== 0 || scl_falls !== f0) begin
            bad++; $display("FAIL busy_start_ignored: got dones=%0d busy_cycles=%0d scl_falls=%0d want 1 0 0",
                            done_cnt - d0, busy_seen, scl_falls - f0);
        end
        ENB = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat;
        int d0;
        @(negedge CLK);
        slv_addr = 7'h31; slv_present = 1'b1; slv_wack = 1'b1;
        ADDR = 7'h31; RW = 1'b0; WDATA = 8'hA5; ENB = 1'b1; START = 1'b1;
        d0 = done_cnt;
        @(posedge CLK);
        #1;
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL b2b_first_accept: got %b want 1", BUSY); end
        WDATA = 8'h3C;
        wait_done(FULL_LAT + 4 * SLOT, -1, lat);
        total++; if (lat !== FULL_LAT) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, FULL_LAT); end
        total++;
        if (SCL !== 1'b1 || BUSY !== 1'b0) begin
            bad++; $display("FAIL b2b_done_cycle: got scl=%b busy=%b want 1 0", SCL, BUSY);
        end
        @(posedge CLK);
        #1;
        total++;
        if (SCL !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++; $display("FAIL b2b_idle_cycle: got scl=%b busy=%b done=%b want 1 0 0", SCL, BUSY, DONE);
        end
        @(posedge CLK);
        #1;
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: got %b want 1", BUSY); end
        START = 1'b0;
        wait_done(FULL_LAT + 4 * SLOT, -1, lat);
        total++; if (lat !== FULL_LAT) begin bad++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, FULL_LAT); end
        @(posedge CLK);
        #1;
        total++;
        if (frame_bits.size() != 19 || pack_frame() !== {13'd0, 7'h31, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0}) begin
            bad++; $display("FAIL b2b_second_frame: got %0d bits %h want 19 bits %h", frame_bits.size(),
                            pack_frame(), {13'd0, 7'h31, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0});
        end
        repeat (2 * SLOT) @(posedge CLK);
        #1;
        total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_random();
        test_reset_mid();
        test_enable_and_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
